// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback request record.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin one-hot picker: first requester at or after ptr_i wins.
module rr_grant #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] j;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IDX_W'((32'(ptr_i) + k) % N);
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port with one output stage and
// operand forwarding. Define WB_ARB_STATS_EN to add conflict_cnt and a grant trace.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned REQ_IDX_W = $clog2(NUM_REQ),
  parameter int unsigned DATA_W    = REG_DATA_W,
  parameter int unsigned ADDR_W    = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      freeze,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [REQ_IDX_W-1:0]      wr_src,
  input  logic [ADDR_W-1:0]         fwd_addr_a,
  input  logic [ADDR_W-1:0]         fwd_addr_b,
  output logic                      fwd_hit_a,
  output logic                      fwd_hit_b,
  output logic [DATA_W-1:0]         fwd_data_a,
  output logic [DATA_W-1:0]         fwd_data_b
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]               conflict_cnt
`endif
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO);

  logic [REQ_IDX_W-1:0] ptr_q, ptr_d;
  logic [REQ_IDX_W-1:0] gnt_idx;
  logic [NUM_REQ-1:0]   req_eff, gnt;
  logic                 any_gnt;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_data;

  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  logic [REQ_IDX_W-1:0] wr_src_q, wr_src_d;

  // Requests are hidden from the picker during reset and freeze so no ready escapes.
  assign req_eff = (rst_n && !freeze) ? req_valid : '0;

  rr_grant #(
    .N     (NUM_REQ),
    .IDX_W (REQ_IDX_W)
  ) u_rr_grant (
    .req_i (req_eff),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (any_gnt)
  );

  assign req_ready = gnt;
  assign sel_addr  = req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[32'(gnt_idx)*DATA_W +: DATA_W];

  always_comb begin
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_src_d  = wr_src_q;
    if (any_gnt) begin
      // An R0 write still takes its slot but never strobes the register file.
      wr_en_d   = (sel_addr != ZeroAddr);
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
      wr_src_d  = gnt_idx;
      ptr_d     = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_src_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_src  = wr_src_q;

  assign fwd_hit_a  = wr_en_q && (wr_addr_q == fwd_addr_a) && (fwd_addr_a != ZeroAddr);
  assign fwd_hit_b  = wr_en_q && (wr_addr_q == fwd_addr_b) && (fwd_addr_b != ZeroAddr);
  assign fwd_data_a = fwd_hit_a ? wr_data_q : '0;
  assign fwd_data_b = fwd_hit_b ? wr_data_q : '0;

`ifdef WB_ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;
  logic        multi_valid;

  assign multi_valid = |(req_valid & (req_valid - 1'b1));

  always_comb begin
    conflict_d = conflict_q;
    if (multi_valid && !freeze && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
      if (any_gnt) begin
        $display("[regfile_wb_arbiter] Grant: req%0d R%0d <= 0x%08h", gnt_idx, sel_addr, sel_data);
      end
    end
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scoreboard bench: stimulus pushes expected writes, a monitor checks wr_* as they appear.
module tb_regfile_wb_arbiter;

  localparam int NR = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              freeze;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [1:0]        wr_src;
  logic [AW-1:0]     fwd_addr_a, fwd_addr_b;
  logic              fwd_hit_a, fwd_hit_b;
  logic [DW-1:0]     fwd_data_a, fwd_data_b;
`ifdef WB_ARB_STATS_EN
  logic [15:0]       conflict_cnt;
`endif

  regfile_wb_arbiter #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .ADDR_W  (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .freeze     (freeze),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_src     (wr_src),
    .fwd_addr_a (fwd_addr_a),
    .fwd_addr_b (fwd_addr_b),
    .fwd_hit_a  (fwd_hit_a),
    .fwd_hit_b  (fwd_hit_b),
    .fwd_data_a (fwd_data_a),
    .fwd_data_b (fwd_data_b)
`ifdef WB_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    src;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   done  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i]        = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic drop_all();
    req_valid = '0;
  endtask

  // Expected write appears after the coming rising edge.
  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] s);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.src  = s;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Drive at the falling edge; settle before checking combinational outputs.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  // Monitor: every write strobe must match the head of the scoreboard, in the right cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!done && wr_en === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL wr_unexpected: got R%0d=0x%08h src %0d at cycle %0d, required no write",
                   wr_addr, wr_data, wr_src, cyc);
        end else begin
          e = exp_q.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data || wr_src !== e.src || cyc != e.cyc) begin
            n_err++;
            $display("FAIL wr_write: got R%0d=0x%08h src %0d cycle %0d, required R%0d=0x%08h src %0d cycle %0d",
                     wr_addr, wr_data, wr_src, cyc, e.addr, e.data, e.src, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    freeze     = 1'b0;
    fwd_addr_a = '0;
    fwd_addr_b = '0;
    req_valid  = '0;
    req_addr   = '0;
    req_data   = '0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i + 1), 32'h1000_0000 + 32'(i));

    // Reset held two cycles with every requester valid.
    for (int k = 0; k < 2; k++) begin
      step(); settle();
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_wr_en", 64'(wr_en), 64'h0);
      chk("rst_wr_addr", 64'(wr_addr), 64'h0);
      chk("rst_wr_data", 64'(wr_data), 64'h0);
    end

    // Round-robin with all four valid: grants 0,1,2,3,0.
    step(); rst_n = 1'b1; settle();
    chk("rr_ready0", 64'(req_ready), 64'b0001);
    push(5'd1, 32'h1000_0000, 2'd0);
    for (int k = 1; k < 5; k++) begin
      step(); settle();
      chk("rr_ready", 64'(req_ready), 64'(4'b0001 << (k % NR)));
      push(AW'((k % NR) + 1), 32'h1000_0000 + 32'(k % NR), 2'(k % NR));
    end
    step(); drop_all(); settle();
    chk("idle_ready", 64'(req_ready), 64'h0);

    // R0 write from req2 (ptr=1): handshaked, no strobe, ptr moves to 3.
    step(); set_req(2, 1'b1, 5'd0, 32'hDEAD_BEEF); settle();
    chk("r0_ready", 64'(req_ready), 64'b0100);
    step(); set_req(3, 1'b1, 5'd9, 32'h0000_0903); settle();
    chk("r0_no_wr_en", 64'(wr_en), 64'h0);
    chk("r0_ptr3_ready", 64'(req_ready), 64'b1000);
    push(5'd9, 32'h0000_0903, 2'd3);

    // Forwarding (ptr=0): req1 writes R7.
    step(); drop_all(); set_req(1, 1'b1, 5'd7, 32'h1234_5678);
    fwd_addr_a = 5'd7; fwd_addr_b = 5'd0; settle();
    chk("fwd_ready", 64'(req_ready), 64'b0010);
    push(5'd7, 32'h1234_5678, 2'd1);
    step(); drop_all(); settle();
    chk("fwd_hit_a", 64'(fwd_hit_a), 64'h1);
    chk("fwd_data_a", 64'(fwd_data_a), 64'h1234_5678);
    chk("fwd_hit_b_r0", 64'(fwd_hit_b), 64'h0);
    chk("fwd_data_b_r0", 64'(fwd_data_b), 64'h0);
    fwd_addr_b = 5'd7; #1;
    chk("fwd_hit_b", 64'(fwd_hit_b), 64'h1);
    chk("fwd_data_b", 64'(fwd_data_b), 64'h1234_5678);
    step(); settle();
    chk("fwd_stale_hit", 64'(fwd_hit_a), 64'h0);
    chk("fwd_stale_data", 64'(fwd_data_a), 64'h0);

    // Freeze (ptr=2): req0 granted by wrap, then freeze with req1/req3 waiting.
    step(); set_req(0, 1'b1, 5'd10, 32'h0000_00A0); settle();
    chk("frz_pre_ready", 64'(req_ready), 64'b0001);
    push(5'd10, 32'h0000_00A0, 2'd0);
    step(); drop_all(); freeze = 1'b1;
    set_req(1, 1'b1, 5'd11, 32'h0000_00B1); set_req(3, 1'b1, 5'd13, 32'h0000_00D3); settle();
    chk("frz_ready", 64'(req_ready), 64'h0);
    chk("frz_staged_wr", 64'(wr_en), 64'h1);
    step(); settle();
    chk("frz_ready2", 64'(req_ready), 64'h0);
    chk("frz_wr_en", 64'(wr_en), 64'h0);
    step(); freeze = 1'b0; settle();
    chk("frz_resume", 64'(req_ready), 64'b0010);
    push(5'd11, 32'h0000_00B1, 2'd1);
    step(); req_valid[1] = 1'b0; settle();
    chk("frz_next", 64'(req_ready), 64'b1000);
    push(5'd13, 32'h0000_00D3, 2'd3);

    // Same address (ptr=0 -> 3 via req2): req3 then req0 write R5.
    step(); drop_all(); set_req(2, 1'b1, 5'd12, 32'h0000_00C2); settle();
    chk("same_setup", 64'(req_ready), 64'b0100);
    push(5'd12, 32'h0000_00C2, 2'd2);
    step(); drop_all();
    set_req(0, 1'b1, 5'd5, 32'h0000_000A); set_req(3, 1'b1, 5'd5, 32'h0000_000B); settle();
    chk("same_first", 64'(req_ready), 64'b1000);
    push(5'd5, 32'h0000_000B, 2'd3);
    step(); req_valid[3] = 1'b0; settle();
    chk("same_second", 64'(req_ready), 64'b0001);
    push(5'd5, 32'h0000_000A, 2'd0);
    step(); drop_all(); settle();
    chk("same_last_data", 64'(wr_data), 64'h0000_000A);

    // Reset during a would-be handshake (ptr=1), then restart from req0.
    step(); set_req(1, 1'b1, 5'd20, 32'h0000_0141); rst_n = 1'b0; settle();
    chk("mrst_ready", 64'(req_ready), 64'h0);
    step(); settle();
    chk("mrst_wr_en", 64'(wr_en), 64'h0);
    chk("mrst_wr_addr", 64'(wr_addr), 64'h0);
    rst_n = 1'b1; set_req(0, 1'b1, 5'd21, 32'h0000_0150); #1;
    chk("mrst_first", 64'(req_ready), 64'b0001);
    push(5'd21, 32'h0000_0150, 2'd0);
    step(); req_valid[0] = 1'b0; settle();
    chk("mrst_second", 64'(req_ready), 64'b0010);
    push(5'd20, 32'h0000_0141, 2'd1);
    step(); drop_all();

    for (int k = 0; k < 3; k++) step();
    chk("sb_drained", 64'(exp_q.size()), 64'h0);
    done = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NUM_REQ writeback requesters, e.g. ALU, load unit, multiply/divide, debug.
- Uses rotating round-robin priority with a valid/ready handshake per requester.
- Holds the granted write in one output register stage that drives the register file's write port.
- Provides a two-port forwarding query so operand reads see the in-flight write.

Parameters:
- NUM_REQ, 4, number of writeback requesters (2..8).
- REQ_IDX_W, $clog2(NUM_REQ), width of requester index.
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (32 registers, R0 hardwired zero).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_W  packed destination register; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed write data, same packing.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high.
- freeze  in  1  when high, no grants are issued and the pointer holds.
- wr_en  out  1  drives the register file write_en.
- wr_addr  out  ADDR_W  drives the register file addr_w.
- wr_data  out  DATA_W  drives the register file data_w.
- wr_src  out  REQ_IDX_W  index of the requester that produced the current write.
- fwd_addr_a, fwd_addr_b  in  ADDR_W  operand addresses being read this cycle.
- fwd_hit_a, fwd_hit_b  out  1  the in-flight write targets that address.
- fwd_data_a, fwd_data_b  out  DATA_W  in-flight data when hit, else 0.

Behaviour:
- Reset (rst_n low at a clk edge):
  - wr_en=0, wr_addr=0, wr_data=0, wr_src=0.
  - Round-robin pointer=0.
  - req_ready is 0 while rst_n is low.
  - Reset mid-transfer discards the staged write. No write reaches the register file on the reset edge or the cycle after.
- Grant (combinational):
  - Search starts at index ptr and wraps modulo NUM_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1.
  - At most one ready bit is high. All ready bits are 0 if freeze=1 or no valid is asserted.
- Output stage:
  - The register file always accepts, so the stage never backpressures.
  - On a clock edge with a grant to i: wr_en<=1, wr_addr<=req_addr[i], wr_data<=req_data[i], wr_src<=i.
  - Otherwise wr_en<=0; wr_addr, wr_data and wr_src hold.
  - Latency is exactly 1 cycle from handshake to wr_en; sustained throughput is 1 write per cycle.
- Pointer update:
  - After a grant to i, ptr<=(i+1) mod NUM_REQ.
  - With no grant, ptr holds.
  - Wrap: a grant at NUM_REQ-1 sets ptr=0.
- R0 writes:
  - A request with addr=0 is still handshaked and consumes its round-robin slot.
  - The output stage drives wr_en=0 for it. R0 never sees a write strobe.
- Forwarding:
  - fwd_hit_x = wr_en && (wr_addr==fwd_addr_x) && (fwd_addr_x!=0).
  - fwd_data_x = fwd_hit_x ? wr_data : 0.
  - Purely combinational from the output stage. It covers the cycle in which the register file has not yet latched the write.
- Simultaneous events:
  - Several requesters target the same register: they are serialised in round-robin order, and the last one granted wins in the register file.
  - freeze asserted with wr_en=1: the staged write still completes on that cycle; only new grants are blocked.
- Protocol:
  - A requester holds valid, addr and data stable until it sees ready.
  - The arbiter never deasserts a grant in a cycle without a clock edge; the grant is combinational and the requester samples it at the edge.
- Fairness: with all requesters continuously valid, each is granted exactly once every NUM_REQ cycles.

Optional Feature:
- Macro WB_ARB_STATS_EN.
- Defined:
  - Adds output conflict_cnt (16 bits).
  - Counts cycles with more than one req_valid asserted while freeze=0.
  - Saturates at 16'hFFFF and resets to 0.
  - Adds a $display trace of each grant: "[regfile_wb_arbiter] Grant: req%0d R%0d <= 0x%08h".
- Undefined: no port, no counter, no display; all other behaviour identical.

Decomposition:
- Shared package regfile_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32.
  - REG_ZERO=5'd0.
  - Typedef wb_req_t {addr, data}.
- One sub-module: rr_grant, a pure combinational round-robin one-hot picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, grant index, any_grant.
  - Reusable by the future memory-port arbiter.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with all valid=1 -> req_ready=0, wr_en=0, wr_addr=0, wr_data=0 throughout. The first grant after release goes to req0.
- Round-robin: all 4 requests held valid with addr=1..4 -> grants 0,1,2,3,0 on consecutive cycles. wr_addr sequence 1,2,3,4,1 appears one cycle later.
- R0 drop: req2 valid with addr=0, data=0xDEADBEEF -> req_ready[2]=1 and ptr advances to 3. wr_en stays 0 the next cycle.
- Forwarding: req1 writes R7=0x12345678, fwd_addr_a=7, fwd_addr_b=0 -> the next cycle fwd_hit_a=1 with fwd_data_a=0x12345678, and fwd_hit_b=0.
- Freeze: freeze=1 in the cycle after a grant -> that staged write still appears (wr_en=1), no new ready, and ptr holds. After freeze drops, arbitration resumes from the held ptr.
- Same-address and mid-operation reset: req0 and req3 both write R5 (0xA, 0xB) with ptr=3 -> R5 receives 0xB then 0xA. Asserting rst_n=0 in the cycle of a handshake -> no wr_en pulse follows.
